// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and default parameters for the two-requester APB arbiter.
//   arb_state_e : arbiter FSM states, one per APB master phase plus a start step
//   owner_e     : which requester currently owns the bus
//   DEF_*       : default parameter values for apb_req_arbiter
//   other_owner : the requester that is not the given one
package apb_arb_pkg;
    typedef enum logic [1:0] {A_IDLE, A_START, A_SETUP, A_ACCESS} arb_state_e;
    typedef enum logic {OWN_0, OWN_1} owner_e;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_STROBE_WIDTH   = 4;
    localparam int DEF_SLAVES_NUM     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 16;
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_0) ? OWN_1 : OWN_0;
    endfunction
endpackage

// File: rtl/apb_arb_rr_pick.sv
// apb_arb_rr_pick: two-way round-robin choice.
//   req_i  : {REQ_1, REQ_0}
//   last_i : requester served most recently
//   win_o  : chosen requester (don't-care when no request is present)
module apb_arb_rr_pick
    import apb_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_i,
    output owner_e     win_o
);
    assign win_o = (req_i == 2'b11) ? other_owner(last_i) : (req_i[1] ? OWN_1 : OWN_0);
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter feeding two requesters into one APB master.
//   PCLK/PRESET            : clock, synchronous active-high reset
//   REQ_x, ADDR_x, WDATA_x,
//   WRITE_x, STRB_x,
//   PROT_x, SEL_x          : requester x transfer request and its fields
//   DONE_x, RDATA, ERR     : registered completion pulse, read data, error flag
//   Transfer .. SEL_in     : request inputs of the APB master
//   PREADY/PSLVERR/PRDATA  : tapped from the APB bus
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int STROBE_WIDTH   = DEF_STROBE_WIDTH,
    parameter int SLAVES_NUM     = DEF_SLAVES_NUM,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    REQ_0,
    input  logic                    REQ_1,
    input  logic [ADDR_WIDTH-1:0]   ADDR_0,
    input  logic [ADDR_WIDTH-1:0]   ADDR_1,
    input  logic [DATA_WIDTH-1:0]   WDATA_0,
    input  logic [DATA_WIDTH-1:0]   WDATA_1,
    input  logic                    WRITE_0,
    input  logic                    WRITE_1,
    input  logic [STROBE_WIDTH-1:0] STRB_0,
    input  logic [STROBE_WIDTH-1:0] STRB_1,
    input  logic [2:0]              PROT_0,
    input  logic [2:0]              PROT_1,
    input  logic [SLAVES_NUM-1:0]   SEL_0,
    input  logic [SLAVES_NUM-1:0]   SEL_1,
    output logic                    DONE_0,
    output logic                    DONE_1,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic                    ERR,
    output logic                    Transfer,
    output logic [ADDR_WIDTH-1:0]   ADDR_in,
    output logic [DATA_WIDTH-1:0]   DATA_in,
    output logic                    WRITE_in,
    output logic [STROBE_WIDTH-1:0] STROB_in,
    output logic [2:0]              PROT_in,
    output logic [SLAVES_NUM-1:0]   SEL_in,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic [DATA_WIDTH-1:0]   PRDATA
);
    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d, win, src;
    logic [1:0]            done_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  other_req, in_access, timeout, err_now, complete, switch_own, own_write;

    apb_arb_rr_pick u_pick (
        .req_i  ({REQ_1, REQ_0}),
        .last_i (owner_q),
        .win_o  (win)
    );

    assign other_req  = (owner_q == OWN_0) ? REQ_1 : REQ_0;
    assign own_write  = (owner_q == OWN_0) ? WRITE_0 : WRITE_1;
    assign in_access  = state_q == A_ACCESS;
    assign err_now    = PSLVERR || timeout;
    assign complete   = in_access && (PREADY || err_now);
    assign switch_own = complete && other_req && !err_now;
    // On a back-to-back handover the next owner's fields go out in the completing cycle.
    assign src        = switch_own ? other_owner(owner_q) : owner_q;
    assign Transfer   = (state_q == A_START) || (state_q == A_SETUP) ||
                        (in_access && (!PREADY || other_req) && !err_now);

    assign ADDR_in  = Transfer ? ((src == OWN_1) ? ADDR_1  : ADDR_0)  : '0;
    assign DATA_in  = Transfer ? ((src == OWN_1) ? WDATA_1 : WDATA_0) : '0;
    assign WRITE_in = Transfer ? ((src == OWN_1) ? WRITE_1 : WRITE_0) : 1'b0;
    assign STROB_in = Transfer ? ((src == OWN_1) ? STRB_1  : STRB_0)  : '0;
    assign PROT_in  = Transfer ? ((src == OWN_1) ? PROT_1  : PROT_0)  : '0;
    assign SEL_in   = Transfer ? ((src == OWN_1) ? SEL_1   : SEL_0)   : '0;

    assign DONE_0 = done_q[0];
    assign DONE_1 = done_q[1];
    assign RDATA  = rdata_q;
    assign ERR    = err_q;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt_q, tcnt_d;
    // Counts ACCESS cycles already spent; cleared whenever ACCESS is (re)entered.
    assign tcnt_d  = (in_access && !complete) ? tcnt_q + 1'b1 : '0;
    assign timeout = in_access && (tcnt_q >= CW'(TIMEOUT_CYCLES));
    always_ff @(posedge PCLK) begin
        tcnt_q <= PRESET ? '0 : tcnt_d;
    end
`else
    // Watchdog compiled out: the comparison is constant false.
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            A_IDLE: begin
                state_d = (REQ_0 || REQ_1) ? A_START : A_IDLE;
                owner_d = (REQ_0 || REQ_1) ? win : owner_q;
            end
            A_START: state_d = A_SETUP;
            A_SETUP: state_d = A_ACCESS;
            default: begin
                state_d = complete ? (switch_own ? A_SETUP : A_IDLE) : A_ACCESS;
                owner_d = src;
            end
        endcase
    end

    // owner_q doubles as the round-robin pointer; resetting it to requester 1
    // makes requester 0 win the first tie.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= A_IDLE;
            owner_q <= OWN_1;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            done_q  <= complete ? ((owner_q == OWN_1) ? 2'b10 : 2'b01) : 2'b00;
            err_q   <= complete ? err_now : err_q;
            rdata_q <= (complete && !own_write) ? PRDATA : rdata_q;
        end
    end
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have these parameters:
- DATA_WIDTH, 32, data width.
- ADDR_WIDTH, 32, address width.
- STROBE_WIDTH, 4, byte-strobe width.
- SLAVES_NUM, 2, width of the one-hot slave select.
- TIMEOUT_CYCLES, 16, ACCESS watchdog limit.
REQ-002 SHALL have these ports:
- PCLK  in  1  sole clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- REQ_0/REQ_1  in  1 each  requester transfer request.
- ADDR_0/ADDR_1  in  ADDR_WIDTH each  requester address.
- WDATA_0/WDATA_1  in  DATA_WIDTH each  write data.
- WRITE_0/WRITE_1  in  1 each  1 = write, 0 = read.
- STRB_0/STRB_1  in  STROBE_WIDTH each  byte strobes.
- PROT_0/PROT_1  in  3 each  protection attributes.
- SEL_0/SEL_1  in  SLAVES_NUM each  one-hot slave select.
- DONE_0/DONE_1  out  1 each  one-cycle completion pulse.
- RDATA  out  DATA_WIDTH  read data of the completed transfer.
- ERR  out  1  error flag of the completed transfer.
- Transfer, ADDR_in, DATA_in, WRITE_in, STROB_in, PROT_in, SEL_in  out  drive the APB master's request inputs; widths match the master.
- PREADY, PSLVERR  in  1 each  tapped from the APB bus.
- PRDATA  in  DATA_WIDTH  tapped from the APB bus.

Function
REQ-003 SHALL implement FSM states A_IDLE, A_START, A_SETUP, A_ACCESS, tracking the master's IDLE/SETUP/ACCESS phases one-to-one.
REQ-004 SHALL, in A_IDLE, use round-robin to pick between REQ_0 and REQ_1 and register the winner as owner; a tie goes to the requester not served last (requester 0 after reset); the FSM moves to A_START.
REQ-005 SHALL drive Transfer=1 in A_START and A_SETUP, and drive every request output from the owner's fields whenever Transfer=1; the request outputs are 0 when Transfer=0.
REQ-006 SHALL advance A_START->A_SETUP->A_ACCESS unconditionally.
REQ-007 SHALL, in A_ACCESS, drive Transfer combinationally as (!PREADY || other_req) && !PSLVERR && !timeout.
REQ-008 SHALL treat completion as A_ACCESS && (PREADY || PSLVERR || timeout). On completion, next cycle: DONE_owner=1, RDATA=PRDATA (reads; unchanged on writes), ERR=PSLVERR||timeout.
REQ-009 SHALL handle a completion with other_req=1 and no error by switching owner to the other requester, whose fields are driven in that same cycle (master captures them into SETUP), and entering A_SETUP: back-to-back, 2 cycles/transfer.
REQ-010 SHALL otherwise go to A_IDLE on completion; an error always forces A_IDLE.
REQ-011 SHALL count REQ_i high in the cycle DONE_i is high as a new request; the owner's own REQ never extends its tenure past completion.
REQ-012 SHALL give zero-wait latency of REQ sampled in cycle 0 (A_IDLE) -> DONE and RDATA valid in cycle 4.
REQ-013 SHALL leave requester fields unchecked; requesters hold them stable until their DONE.

Reset
REQ-014 SHALL, with PRESET high at a PCLK edge, enter A_IDLE, set the round-robin pointer to favour requester 0, and clear the timeout counter. All outputs SHALL be 0, including mid-transfer; no DONE is issued for an aborted transfer.

Configuration
REQ-015 SHALL gate the watchdog with macro APB_ARB_TIMEOUT_EN. When defined, a counter clears on A_ACCESS entry and increments each A_ACCESS cycle; on reaching TIMEOUT_CYCLES, timeout=1. Without the macro, timeout is constant 0, no counter exists, and A_ACCESS waits indefinitely.

Structure
REQ-016 SHALL take from shared package apb_arb_pkg: the FSM state typedef, the two-requester owner typedef, and default parameter constants.
REQ-017 SHALL implement the 2-way round-robin choice in sub-module apb_arb_rr_pick (inputs: requests, last-owner; output: winner).

Verification
REQ-018 SHALL cover these directed scenarios:
- Single read: REQ_0 cycle 0, ADDR_0=0x10, PREADY=1, PRDATA=0xCAFEF00D -> DONE_0=1 and RDATA=0xCAFEF00D in cycle 4, ERR=0.
- Contention: REQ_0 and REQ_1 both high from reset, zero-wait -> DONE_0 cycle 4, DONE_1 cycle 6, no Transfer gap between them.
- Wait states: REQ_1 write, PREADY low 3 A_ACCESS cycles -> Transfer held 1, DONE_1 in cycle 7.
- Slave error: PSLVERR=1 with PREADY=1 while REQ_1 pending -> ERR=1 on DONE_0, FSM returns to A_IDLE, REQ_1 granted afterwards.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): PREADY stuck low -> Transfer drops after 16 A_ACCESS cycles, DONE with ERR=1.
- Reset mid-op: PRESET during A_ACCESS -> next cycle all outputs 0, no DONE, new REQ restarts at A_START.
